// File: rtl/qtable_dump_if.sv
// Q-table dump bus: RAM read port on one side, file-writer stream on the other.
interface qtable_dump_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_valid;
  logic                  dump_stop;

  modport master (
    output mem_rd_en, mem_addr, dump_data, dump_valid, dump_stop,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, dump_data, dump_valid, dump_stop,
    output mem_rd_data
  );
endinterface

// File: rtl/qtable_dump.sv
// Streams Q-table RAM entries 0..NUM_ENTRIES-1 to the file writer, then a stop pulse.
// Optional QDUMP_CHECKSUM_EN appends a running-XOR checksum word before the stop.
//
// state | meaning
// IDLE  | waiting for start; done holds the previous dump's completion
// ISSUE | one RAM read per cycle, addresses in ascending order
// DRAIN | last read in flight; wait for it to reach dump_data
// TAIL  | checksum word on dump_data (checksum build only)
// STOP  | one-cycle dump_stop pulse, then back to IDLE
module qtable_dump #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_ENTRIES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  qtable_dump_if.master      bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
`ifdef QDUMP_CHECKSUM_EN
    S_TAIL,
`endif
    S_STOP
  } state_t;

  // One extra bit so a full 2**ADDR_WIDTH dump terminates without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(NUM_ENTRIES);

  state_t              state;
  logic [ADDR_WIDTH:0] cnt;
  logic                rd_q;
`ifdef QDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rd_q           <= 1'b0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.dump_data  <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_stop  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef QDUMP_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      // rd_q marks RAM data landing this cycle; it becomes dump_valid next cycle.
      rd_q           <= bus.mem_rd_en;
      bus.dump_valid <= rd_q;
      bus.dump_stop  <= 1'b0;
      if (rd_q) begin
        bus.dump_data <= bus.mem_rd_data;
`ifdef QDUMP_CHECKSUM_EN
        csum          <= csum ^ bus.mem_rd_data;
`endif
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_ISSUE;
            busy          <= 1'b1;
            done          <= 1'b0;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= '0;
            cnt           <= (ADDR_WIDTH+1)'(1);
`ifdef QDUMP_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (cnt == LAST_CNT) begin
            bus.mem_rd_en <= 1'b0;
            state         <= S_DRAIN;
          end else begin
            bus.mem_addr <= cnt[ADDR_WIDTH-1:0];
            cnt          <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!rd_q) begin
`ifdef QDUMP_CHECKSUM_EN
            state          <= S_TAIL;
            bus.dump_valid <= 1'b1;
            bus.dump_data  <= csum;
`else
            state          <= S_STOP;
            bus.dump_stop  <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b1;
`endif
          end
        end
`ifdef QDUMP_CHECKSUM_EN
        S_TAIL: begin
          state         <= S_STOP;
          bus.dump_stop <= 1'b1;
          busy          <= 1'b0;
          done          <= 1'b1;
        end
`endif
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qtable_dump.sv
// Bench for qtable_dump: cycle table for a 4-entry dump, hand sequences, random dumps vs a list model.
module tb_qtable_dump;

`ifdef QDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy0, done0, busy1, done1;

  always #5 clk = ~clk;

  qtable_dump_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) b0 ();
  qtable_dump_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) b1 ();

  qtable_dump #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_ENTRIES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(b0), .busy(busy0), .done(done0));
  qtable_dump #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_ENTRIES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(b1), .busy(busy1), .done(done1));

  logic [15:0] ram0 [4];
  logic [15:0] ram1 [256];

  always @(posedge clk) begin
    if (b0.mem_rd_en) b0.mem_rd_data <= ram0[b0.mem_addr];
    if (b1.mem_rd_en) b1.mem_rd_data <= ram1[b1.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] data; } word_t;
  word_t w0_q[$], w1_q[$];
  int stop0_q[$], stop1_q[$], rd0_q[$], rd1_q[$];
  int clash = 0;

  always @(negedge clk) begin
    if (b0.dump_valid) w0_q.push_back('{cyc, b0.dump_data});
    if (b0.dump_stop)  stop0_q.push_back(cyc);
    if (b0.mem_rd_en)  rd0_q.push_back(int'(b0.mem_addr));
    if (b1.dump_valid) w1_q.push_back('{cyc, b1.dump_data});
    if (b1.dump_stop)  stop1_q.push_back(cyc);
    if (b1.mem_rd_en)  rd1_q.push_back(int'(b1.mem_addr));
    if ((b0.dump_valid && b0.dump_stop) || (b1.dump_valid && b1.dump_stop)) clash++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_start(input int k, input logic v);
    if (k == 0) start0 = v;
    else        start1 = v;
  endtask

  // Starts a dump on DUT k, optionally re-pulses start at offset roff, then checks the whole stream.
  task automatic run_dump(input int k, input int roff);
    int n, len, stop_off, s, wb, sb, rb;
    logic [15:0] x;
    logic [15:0] exp_q[$];
    word_t cw[$];
    int cs[$], cr[$];
    n = (k == 0) ? 4 : 1;
    x = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((k == 0) ? ram0[i] : ram1[i]);
      x = x ^ exp_q[i];
    end
    if (CS == 1) exp_q.push_back(x);
    len = n + CS;
    stop_off = 3 + len;
    if (k == 0) begin wb = w0_q.size(); sb = stop0_q.size(); rb = rd0_q.size(); end
    else        begin wb = w1_q.size(); sb = stop1_q.size(); rb = rd1_q.size(); end
    s = cyc;
    set_start(k, 1'b1);
    for (int c = 1; c <= stop_off + 8; c++) begin
      wait_until(s + c);
      set_start(k, c == roff);
      if (c == 1) begin
        chk("busy_after_start", 32'((k == 0) ? busy0 : busy1), 32'd1);
        chk("done_cleared", 32'((k == 0) ? done0 : done1), 32'd0);
      end
    end
    set_start(k, 1'b0);
    if (k == 0) begin cw = w0_q; cs = stop0_q; cr = rd0_q; end
    else        begin cw = w1_q; cs = stop1_q; cr = rd1_q; end
    chk("word_count", 32'(cw.size() - wb), 32'(len));
    for (int i = 0; i < len; i++) begin
      if (wb + i < cw.size()) begin
        chk("word_data", 32'(cw[wb+i].data), 32'(exp_q[i]));
        chk("word_cycle", 32'(cw[wb+i].cyc - s), 32'(3 + i));
      end
    end
    chk("stop_count", 32'(cs.size() - sb), 32'd1);
    if (sb < cs.size()) chk("stop_cycle", 32'(cs[sb] - s), 32'(stop_off));
    chk("rd_count", 32'(cr.size() - rb), 32'(n));
    for (int i = 0; i < n; i++)
      if (rb + i < cr.size()) chk("rd_addr", 32'(cr[rb+i]), 32'(i));
    chk("done_end", 32'((k == 0) ? done0 : done1), 32'd1);
    chk("busy_end", 32'((k == 0) ? busy0 : busy1), 32'd0);
  endtask

  typedef struct {
    int          off;
    logic        rd;
    logic [1:0]  addr;
    logic        valid;
    logic [15:0] data;
    logic        stop;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int s, sb;
    tbl[0] = '{0, 1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1, 1'b1, 2'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2, 1'b1, 2'd1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{3, 1'b1, 2'd2, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4, 1'b1, 2'd3, 1'b1, 16'd2, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{5, 1'b0, 2'd0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{6, 1'b0, 2'd0, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0};
`ifdef QDUMP_CHECKSUM_EN
    tbl[7] = '{7, 1'b0, 2'd0, 1'b1, 16'd4, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8, 1'b0, 2'd0, 1'b0, 16'd4, 1'b1, 1'b0, 1'b1};
`else
    tbl[7] = '{7, 1'b0, 2'd0, 1'b0, 16'd4, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{8, 1'b0, 2'd0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1};
`endif
    tbl[9] = '{9, 1'b0, 2'd0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) ram0[i] = 16'(i + 1);
    for (int i = 0; i < 256; i++) ram1[i] = 16'h0;
    ram1[0] = 16'hBEEF;

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(b0.mem_rd_en), 32'd0);
    chk("rst_valid", 32'(b0.dump_valid), 32'd0);
    chk("rst_stop", 32'(b0.dump_stop), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_data", 32'(b1.dump_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-exact 4-entry dump, RAM[i]=i+1.
    s = cyc;
    start0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_until(s + tbl[i].off);
      if (cyc >= s + 1) start0 = 1'b0;
      chk("tbl_valid", 32'(b0.dump_valid), 32'(tbl[i].valid));
      chk("tbl_data", 32'(b0.dump_data), 32'(tbl[i].data));
      chk("tbl_stop", 32'(b0.dump_stop), 32'(tbl[i].stop));
      chk("tbl_busy", 32'(busy0), 32'(tbl[i].busy));
      chk("tbl_done", 32'(done0), 32'(tbl[i].done));
      chk("tbl_rd_en", 32'(b0.mem_rd_en), 32'(tbl[i].rd));
      if (tbl[i].rd) chk("tbl_addr", 32'(b0.mem_addr), 32'(tbl[i].addr));
    end
    repeat (3) @(negedge clk);

    // Start re-pulsed at cycle 4 of a dump is ignored.
    run_dump(0, 4);

    // Reset mid-dump: everything clears, no stop pulse.
    s = cyc;
    start0 = 1'b1;
    wait_until(s + 1);
    start0 = 1'b0;
    wait_until(s + 5);
    rst_n = 1'b0;
    wait_until(s + 6);
    chk("midrst_rd_en", 32'(b0.mem_rd_en), 32'd0);
    chk("midrst_addr", 32'(b0.mem_addr), 32'd0);
    chk("midrst_valid", 32'(b0.dump_valid), 32'd0);
    chk("midrst_data", 32'(b0.dump_data), 32'd0);
    chk("midrst_stop", 32'(b0.dump_stop), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    sb = stop0_q.size();
    rst_n = 1'b1;
    wait_until(s + 16);
    chk("midrst_no_stop", 32'(stop0_q.size() - sb), 32'd0);
    run_dump(0, 0);

    // Single-entry dump; second run re-pulses start in the STOP cycle.
    run_dump(1, 0);
    run_dump(1, 4 + CS);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) ram0[i] = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_dump(0, $urandom_range(0, 7 + CS));
    end

    chk("valid_stop_clash", 32'(clash), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
